// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache.
// Sits between the MEM stage and the SRAM controller. Read hits return data
// combinationally in the request cycle. Read misses and all writes go to SRAM
// while the pipeline is held through a low ready.
module cache_controller #(
   parameter int unsigned IDX_W = 6,
   parameter int unsigned TAG_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        sram_rd_en,
   output logic        sram_wr_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ready
);

   localparam int unsigned SETS   = 1 << IDX_W;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WADR_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RMISS = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Per-set line state; valid and lru are reset, tag/data need no reset
   logic [SETS-1:0]   valid0_q, valid1_q, lru_q;
   logic [TAG_W-1:0]  tag0_q  [SETS];
   logic [TAG_W-1:0]  tag1_q  [SETS];
   logic [DATA_W-1:0] data0_q [SETS];
   logic [DATA_W-1:0] data1_q [SETS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              hit0, hit1, hit;
   logic [DATA_W-1:0] hit_data;
   logic              victim_way;

   // Array update controls computed in the next-state logic
   logic              fill_en;
   logic              fill_way;
   logic              wupd_en;
   logic              wupd_way;
   logic              lru_we;
   logic              lru_val;

   // Address bits outside the 18-bit word space are ignored
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{address[31:18], address[1:0]};

   // Address split and SRAM-side pass-through
   assign idx          = address[2 +: IDX_W];
   assign tag          = address[2 + IDX_W +: TAG_W];
   assign sram_address = {14'b0, address[2 +: WADR_W], 2'b00};
   assign sram_wdata   = write_data;
   assign sram_rd_en   = (state_q == S_RMISS);
   assign sram_wr_en   = (state_q == S_WRITE);

   // Tag lookup on both ways; hit data falls back to zero so it is never X
   always_comb begin
      hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
      hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
      hit      = hit0 || hit1;
      hit_data = '0;
      if (hit1) begin
         hit_data = data1_q[idx];
      end else if (hit0) begin
         hit_data = data0_q[idx];
      end
   end

   // Fill victim: first invalid way (way0 first), otherwise the LRU way
   always_comb begin
      if (!valid0_q[idx]) begin
         victim_way = 1'b0;
      end else if (!valid1_q[idx]) begin
         victim_way = 1'b1;
      end else begin
         victim_way = lru_q[idx];
      end
   end

   // Next-state, handshake outputs and cache update controls
   always_comb begin
      state_d   = state_q;
      ready     = 1'b1;
      read_data = hit_data;
      fill_en   = 1'b0;
      fill_way  = 1'b0;
      wupd_en   = 1'b0;
      wupd_way  = 1'b0;
      lru_we    = 1'b0;
      lru_val   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_en) begin
               ready   = 1'b0;
               state_d = S_WRITE;
            end else if (rd_en) begin
               if (hit) begin
                  ready   = 1'b1;
                  lru_we  = 1'b1;
                  lru_val = ~hit1;
               end else begin
                  ready   = 1'b0;
                  state_d = S_RMISS;
               end
            end
         end
         S_RMISS: begin
            if (sram_ready) begin
               ready     = 1'b1;
               read_data = sram_rdata;
               state_d   = S_IDLE;
               // An abandoned read still completes on the bus but is not cached
               if (rd_en) begin
                  fill_en  = 1'b1;
                  fill_way = victim_way;
                  lru_we   = 1'b1;
                  lru_val  = ~victim_way;
               end
            end else begin
               ready = 1'b0;
            end
         end
         S_WRITE: begin
            if (sram_ready) begin
               ready   = 1'b1;
               state_d = S_IDLE;
               // Write-through: refresh a resident copy, never allocate
               if (hit) begin
                  wupd_en  = 1'b1;
                  wupd_way = hit1;
                  lru_we   = 1'b1;
                  lru_val  = ~hit1;
               end
            end else begin
               ready = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, valid and LRU registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         state_q <= state_d;
         if (lru_we) begin
            lru_q[idx] <= lru_val;
         end
         if (fill_en) begin
            if (fill_way) begin
               valid1_q[idx] <= 1'b1;
            end else begin
               valid0_q[idx] <= 1'b1;
            end
         end
      end
   end

   // Tag and data storage; contents are qualified by valid so need no reset
   always_ff @(posedge clk) begin
      if (fill_en) begin
         if (fill_way) begin
            tag1_q[idx]  <= tag;
            data1_q[idx] <= sram_rdata;
         end else begin
            tag0_q[idx]  <= tag;
            data0_q[idx] <= sram_rdata;
         end
      end
      if (wupd_en) begin
         if (wupd_way) begin
            data1_q[idx] <= write_data;
         end else begin
            data0_q[idx] <= write_data;
         end
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural SRAM controller model
// that answers on the 6th consecutive enabled cycle; unwritten words read w*3.
module tb_cache_controller;

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ready;

   int n_checks = 0;
   int n_fail   = 0;

   cache_controller dut (
      .clk          (clk),
      .rst          (rst),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .address      (address),
      .write_data   (write_data),
      .read_data    (read_data),
      .ready        (ready),
      .sram_rd_en   (sram_rd_en),
      .sram_wr_en   (sram_wr_en),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM controller model
   logic [31:0] wmem [int];
   int          en_cnt = 0;
   logic        sram_en;

   function automatic logic [31:0] mem_rd(input logic [15:0] w);
      if (wmem.exists(int'(w))) return wmem[int'(w)];
      return 32'(w) * 32'd3;
   endfunction

   assign sram_en    = sram_rd_en | sram_wr_en;
   assign sram_ready = sram_en && (en_cnt == 5);
   assign sram_rdata = sram_ready ? mem_rd(sram_address[17:2]) : 32'h0;

   always @(posedge clk) begin
      if (sram_en && !sram_ready) en_cnt <= en_cnt + 1;
      else                        en_cnt <= 0;
      if (sram_ready && sram_wr_en) wmem[int'(sram_address[17:2])] = sram_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One request held until ready; checks latency, SRAM enable cycles and data
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input int exp_rdc, input int exp_wrc,
                         input logic chk_data, input logic [31:0] exp_data);
      int          n;
      int          rdc;
      int          wrc;
      logic        done;
      logic [31:0] rdata;
      n = 0; rdc = 0; wrc = 0; done = 1'b0; rdata = '0;
      rd_en = rd; wr_en = wr; address = addr; write_data = wd;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (sram_rd_en) rdc++;
         if (sram_wr_en) wrc++;
         if (ready) begin
            done  = 1'b1;
            rdata = read_data;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
      chk({tag, ".sram_rd_cycles"}, 32'(rdc), 32'(exp_rdc));
      chk({tag, ".sram_wr_cycles"}, 32'(wrc), 32'(exp_wrc));
      if (chk_data) chk({tag, ".read_data"}, rdata, exp_data);
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.ready", 32'(ready), 32'd1);
      chk("reset.sram_rd_en", 32'(sram_rd_en), 32'd0);
      chk("reset.sram_wr_en", 32'(sram_wr_en), 32'd0);
      chk("reset.read_data", read_data, 32'h0);
      @(posedge clk); #1;

      // Read miss then hit
      access("t1.miss40", 1, 0, 32'h40, 32'h0, 7, 6, 0, 1, 32'h30);
      access("t1.hit40",  1, 0, 32'h40, 32'h0, 1, 0, 0, 1, 32'h30);

      // Write hit updates the line; write miss does not allocate
      access("t3.wr40",   0, 1, 32'h40, 32'hDEADBEEF, 7, 0, 6, 0, 32'h0);
      access("t3.hit40",  1, 0, 32'h40, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF);
      access("t3.wr80",   0, 1, 32'h80, 32'h12345678, 7, 0, 6, 0, 32'h0);
      access("t3.rd80",   1, 0, 32'h80, 32'h0, 7, 6, 0, 1, 32'h12345678);

      // Simultaneous read and write: write wins, no fill
      access("t4.rdwr44", 1, 1, 32'h44, 32'hCAFEF00D, 7, 0, 6, 0, 32'h0);
      access("t4.rd44",   1, 0, 32'h44, 32'h0, 7, 6, 0, 1, 32'hCAFEF00D);

      // Set 0 replacement
      access("t2.rd000a", 1, 0, 32'h000, 32'h0, 7, 6, 0, 1, 32'h0);
      access("t2.rd100a", 1, 0, 32'h100, 32'h0, 7, 6, 0, 1, 32'hC0);
      access("t2.hit000", 1, 0, 32'h000, 32'h0, 1, 0, 0, 1, 32'h0);
      access("t2.rd200",  1, 0, 32'h200, 32'h0, 7, 6, 0, 1, 32'h180);
      access("t2.hit000b",1, 0, 32'h000, 32'h0, 1, 0, 0, 1, 32'h0);
      access("t2.rd100b", 1, 0, 32'h100, 32'h0, 7, 6, 0, 1, 32'hC0);

      // Back-to-back hits in both ways of one set
      access("t6.hit000", 1, 0, 32'h000, 32'h0, 1, 0, 0, 1, 32'h0);
      access("t6.hit100", 1, 0, 32'h100, 32'h0, 1, 0, 0, 1, 32'hC0);
      access("t6.hit000b",1, 0, 32'h000, 32'h0, 1, 0, 0, 1, 32'h0);
      access("t6.hit100b",1, 0, 32'h100, 32'h0, 1, 0, 0, 1, 32'hC0);
      access("t6.hit40",  1, 0, 32'h40,  32'h0, 1, 0, 0, 1, 32'hDEADBEEF);

      // Reset on the 3rd RMISS cycle
      rd_en = 1'b1; address = 32'h300;
      @(negedge clk);
      chk("t5.idle_ready", 32'(ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t5.rmiss_rd_en", 32'(sram_rd_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      chk("t5.post_rst_rd_en", 32'(sram_rd_en), 32'd0);
      chk("t5.post_rst_wr_en", 32'(sram_wr_en), 32'd0);
      chk("t5.post_rst_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      access("t5.rd000", 1, 0, 32'h000, 32'h0, 7, 6, 0, 1, 32'h0);
      access("t5.rd40",  1, 0, 32'h40,  32'h0, 7, 6, 0, 1, 32'hDEADBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
